// File: rtl/dff_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin register arbiter: FSM state
// encoding, a constant-friendly clog2 and the round-robin winner search.
package dff_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // First set request scanning ptr, ptr+1, ... wrapping at n; supports n <= 16.
  function automatic int rr_pick(input logic [15:0] req, input int ptr, input int n);
    int idx;
    int pick;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && req[idx[3:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter. The master modport is the
// requester population, the slave modport is the arbiter itself.
interface dff_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*WIDTH-1:0] i_data;
  logic [N_REQ-1:0]       i_lock;
  logic [N_REQ-1:0]       o_gnt;
  logic [WIDTH-1:0]       o_output;
  logic                   o_valid;

  modport master (
    output i_req, i_data, i_lock,
    input  o_gnt, o_output, o_valid
  );

  modport slave (
    input  i_req, i_data, i_lock,
    output o_gnt, o_output, o_valid
  );
endinterface

// File: rtl/dff_reg_arbiter_bank.sv
// WIDTH-bit storage register with load enable; async active-low reset returns
// it to RESET_VAL immediately, independent of the clock.
module dff_bank_en #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg <= RESET_VAL;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter granting one of N_REQ requesters write access to a shared
// register. Optional grant locking is compiled in with `define ARB_LOCK_EN.
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int               N_REQ     = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               LOCK_MAX  = 4
) (
  input logic              clk,
  input logic              reset_n,
  dff_reg_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? clog2(N_REQ) : 1;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   winner_reg, winner_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic               valid_reg, valid_next;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_wrap;
  logic [15:0]        req_ext;
  logic               wr_en;
  logic               hold;
  logic [WIDTH-1:0]   data_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = bus.i_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = bus.i_req;
  end

  assign pick_idx = IDX_W'(rr_pick(req_ext, int'(ptr_reg), N_REQ));
  assign ptr_wrap = (int'(winner_reg) + 1 == N_REQ) ? '0 : winner_reg + 1'b1;

`ifdef ARB_LOCK_EN
  localparam int CNT_W = clog2(LOCK_MAX + 1) + 1;
  logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
`else
  // Lock requests have no effect in this build.
  logic unused_lock;
  assign unused_lock = ^bus.i_lock;
`endif

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    winner_next = winner_reg;
    gnt_next    = gnt_reg;
    valid_next  = 1'b0;
    wr_en       = 1'b0;
    hold        = 1'b0;
`ifdef ARB_LOCK_EN
    lock_cnt_next = lock_cnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        gnt_next = '0;
        if (|bus.i_req) begin
          winner_next        = pick_idx;
          gnt_next[pick_idx] = 1'b1;
          state_next         = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A dropped request forfeits the slot but still advances the pointer.
        wr_en      = bus.i_req[winner_reg];
        valid_next = wr_en;
`ifdef ARB_LOCK_EN
        hold = wr_en && bus.i_lock[winner_reg] && (int'(lock_cnt_reg) + 1 < LOCK_MAX);
        if (hold) lock_cnt_next = lock_cnt_reg + 1'b1;
        else      lock_cnt_next = '0;
`endif
        if (!hold) begin
          ptr_next   = ptr_wrap;
          gnt_next   = '0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      winner_reg <= '0;
      gnt_reg    <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      winner_reg <= winner_next;
      gnt_reg    <= gnt_next;
      valid_reg  <= valid_next;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lock_cnt_reg <= '0;
    else          lock_cnt_reg <= lock_cnt_next;
  end
`endif

  dff_bank_en #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (wr_en),
    .d       (data_arr[winner_reg]),
    .q       (bus.o_output)
  );

  assign bus.o_gnt   = gnt_reg;
  assign bus.o_valid = valid_reg;
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scoreboard bench for dff_reg_arbiter: a transaction-level model predicts each
// cycle's grant/valid/register value; a monitor compares on every falling edge.
module tb_dff_reg_arbiter;
  localparam int         N  = 4;
  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'h3C;
  localparam int         LM = 4;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] gnt;
    logic         valid;
    logic [W-1:0] out;
  } exp_t;

  logic clk;
  logic reset_n;
  dff_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  dff_reg_arbiter #(
    .N_REQ(N), .WIDTH(W), .RESET_VAL(RV), .LOCK_MAX(LM)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  // Model: which requester currently owns the register, where the scan starts,
  // how many writes the current owner has made, and the register contents.
  int         m_cur;
  int         m_ptr;
  int         m_cnt;
  logic [7:0] m_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1;
    m_ptr = 0;
    m_cnt = 0;
    m_out = RV;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] lock,
                            input logic [N*W-1:0] data, output exp_t e);
    bit found;
    int k;
    e.valid = 1'b0;
    e.gnt   = '0;
    if (m_cur < 0) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (!found && req[k]) begin
          m_cur = k;
          found = 1'b1;
        end
      end
      if (found) e.gnt = N'(1 << m_cur);
    end else begin
      if (req[m_cur]) begin
        m_out   = data[m_cur*W +: W];
        e.valid = 1'b1;
        m_cnt++;
      end
      if (LOCK_EN && req[m_cur] && lock[m_cur] && m_cnt < LM) begin
        e.gnt = N'(1 << m_cur);
      end else begin
        m_ptr = (m_cur + 1) % N;
        m_cur = -1;
        m_cnt = 0;
      end
    end
    e.out = m_out;
  endtask

  // Drive one cycle's inputs just after the falling edge and queue the
  // response expected after the following rising edge.
  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] lock,
                       input logic [N*W-1:0] data);
    exp_t e;
    @(negedge clk);
    #1;
    bus.i_req  = req;
    bus.i_lock = lock;
    bus.i_data = data;
    model_step(req, lock, data, e);
    sb_q.push_back(e);
    $display("cyc t=%0t req=%b lock=%b data=%h -> exp gnt=%b valid=%b out=%h",
             $time, req, lock, data, e.gnt, e.valid, e.out);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("gnt",   32'(bus.o_gnt),    32'(e.gnt));
      chk("valid", 32'(bus.o_valid),  32'(e.valid));
      chk("out",   32'(bus.o_output), 32'(e.out));
    end
  end

  initial begin
    logic [N-1:0]   r;
    logic [N-1:0]   l;
    logic [N*W-1:0] d;

    model_reset();
    // Reset with requests active
    reset_n    = 1'b0;
    bus.i_req  = '1;
    bus.i_lock = '0;
    bus.i_data = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",   32'(bus.o_gnt),    32'h0);
    chk("rst_valid", 32'(bus.o_valid),  32'h0);
    chk("rst_out",   32'(bus.o_output), 32'(RV));
    bus.i_req = '0;
    #2 reset_n = 1'b1;

    // Single request
    cycle(4'b0001, 4'b0000, 32'h000000A5);
    cycle(4'b0001, 4'b0000, 32'h000000A5);
    cycle(4'b0000, 4'b0000, 32'h000000A5);

    // All requesting: rotate through every requester
    repeat (10) cycle(4'b1111, 4'b0000, 32'h13121110);
    cycle(4'b0000, 4'b0000, 32'h13121110);

    // Drop while granted, then full contention
    cycle(4'b0100, 4'b0000, 32'h00770000);
    cycle(4'b0000, 4'b0000, 32'h00770000);
    repeat (4) cycle(4'b1111, 4'b0000, 32'h44332211);
    cycle(4'b0000, 4'b0000, 32'h0);

`ifdef ARB_LOCK_EN
    // Locked winner keeps the register for LM writes, then the scan moves on
    for (int i = 0; i < LM + 1; i++) cycle(4'b0010, 4'b0010, {16'h0, 8'(8'h60 + i), 8'h0});
    repeat (3) cycle(4'b1010, 4'b0000, 32'h9900AA00);
    cycle(4'b0000, 4'b0000, 32'h0);
`endif

    // Async reset while a grant is outstanding
    cycle(4'b0001, 4'b0000, 32'h000000E1);
    @(posedge clk);
    #2;
    sb_q.delete();
    reset_n = 1'b0;
    #1;
    chk("arst_gnt",   32'(bus.o_gnt),    32'h0);
    chk("arst_valid", 32'(bus.o_valid),  32'h0);
    chk("arst_out",   32'(bus.o_output), 32'(RV));
    bus.i_req = '0;
    model_reset();
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2) cycle(4'b0000, 4'b0000, 32'h000000E1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      l = N'($urandom);
      d = $urandom;
      cycle(r, l, d);
    end

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
